// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types for the pipeline stall/flush sequencer.
//   state_t       : 2-bit sequencer state (RUN, MEM_WAIT, HALTED, ERROR)
//   stage_ctrl_t  : per-pipeline-register control (write enable + bubble load)
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_MEM_WAIT = 2'd1;
    localparam state_t ST_HALTED   = 2'd2;
    localparam state_t ST_ERROR    = 2'd3;

    typedef struct packed {
        logic we;
        logic flush;
    } stage_ctrl_t;

    // Common stage-register actions
    localparam stage_ctrl_t STAGE_HOLD    = '{we: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t STAGE_ADVANCE = '{we: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t STAGE_BUBBLE  = '{we: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Combines load-use stall,
// EX taken-branch redirect, data-memory wait and WB halt into PC and stage
// register enables/bubbles, with a memory-wait watchdog and saturating
// stall/flush performance counters.
//
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   load_use_stall                  load in EX feeds instruction in ID
//   ex_branch_taken                 EX redirect (not-taken predicted)
//   dmem_req, dmem_ready            MEM-stage data memory handshake
//   halt_req                        ecall/ebreak in WB
//   pc_we, pc_sel_branch            PC update enable / select branch target
//   if_id_we .. mem_wb_we           stage register write enables
//   if_id_flush, id_ex_flush,
//   mem_wb_flush                    load a bubble into that stage register
//   halted, mem_timeout             sticky stop indications
//   stall_cnt, flush_cnt            saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,   // must be >= 2
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             pc_sel_branch,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);

    // Stage register indices into stage_c
    localparam int S_IF_ID  = 0;
    localparam int S_ID_EX  = 1;
    localparam int S_EX_MEM = 2;
    localparam int S_MEM_WB = 3;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

    stage_ctrl_t [3:0] stage_c;
    logic              pc_we_c;
    logic              pc_sel_c;
    logic              mem_wait;
    logic              active;

    assign mem_wait = dmem_req & ~dmem_ready;
    assign active   = (state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT);

    always_comb begin
        stage_c       = {4{STAGE_HOLD}};
        pc_we_c       = 1'b0;
        pc_sel_c      = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;

        if (active) begin
            if (halt_req) begin
                // WB commits this cycle; everything else freezes for good.
                state_next    = ST_HALTED;
                wait_cnt_next = '0;
            end else if (mem_wait) begin
                // Upstream frozen; WB gets a bubble so the MEM/WB contents
                // are not committed twice. Branch/load-use stay asserted
                // by the frozen EX/ID and are picked up on release.
                stage_c[S_MEM_WB] = STAGE_BUBBLE;
                if (state_reg == ST_RUN) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_next = ST_ERROR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end else begin
                // RUN, or the release cycle of MEM_WAIT
                state_next    = ST_RUN;
                wait_cnt_next = '0;
                if (ex_branch_taken) begin
                    // Squashes IF and ID, so a load-use on ID is moot.
                    pc_we_c           = 1'b1;
                    pc_sel_c          = 1'b1;
                    stage_c[S_IF_ID]  = STAGE_BUBBLE;
                    stage_c[S_ID_EX]  = STAGE_BUBBLE;
                    stage_c[S_EX_MEM] = STAGE_ADVANCE;
                    stage_c[S_MEM_WB] = STAGE_ADVANCE;
                end else if (load_use_stall) begin
                    stage_c[S_ID_EX]  = STAGE_BUBBLE;
                    stage_c[S_EX_MEM] = STAGE_ADVANCE;
                    stage_c[S_MEM_WB] = STAGE_ADVANCE;
                end else begin
                    pc_we_c = 1'b1;
                    stage_c = {4{STAGE_ADVANCE}};
                end
            end
        end
    end

    // EX/MEM has no bubble input; nothing above may ever request one.
    always_comb begin
        assert (!stage_c[S_EX_MEM].flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Control outputs are forced quiet while reset is held, independent of
    // the (already reset) state and the live inputs.
    assign pc_we         = rst_n & pc_we_c;
    assign pc_sel_branch = rst_n & pc_sel_c;
    assign if_id_we      = rst_n & stage_c[S_IF_ID].we;
    assign id_ex_we      = rst_n & stage_c[S_ID_EX].we;
    assign ex_mem_we     = rst_n & stage_c[S_EX_MEM].we;
    assign mem_wb_we     = rst_n & stage_c[S_MEM_WB].we;
    assign if_id_flush   = rst_n & stage_c[S_IF_ID].flush;
    assign id_ex_flush   = rst_n & stage_c[S_ID_EX].flush;
    assign mem_wb_flush  = rst_n & stage_c[S_MEM_WB].flush;
    assign halted        = (state_reg == ST_HALTED);
    assign mem_timeout   = (state_reg == ST_ERROR);

    // Performance counters: [0] stall cycles, [1] branch redirects.
    // Halt cycles are not stalls even though the PC holds.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = active & ~pc_we_c & ~halt_req;
    assign cnt_inc[1] = pc_sel_c;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf_cnt
            sat_counter #(
                .W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt = cnt_val[0];
    assign flush_cnt = cnt_val[1];

endmodule
